arm_exec_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences one ARM instruction at a time: fetch, decode, execute (ALU or multiplier), then writeback.
- Drives the instruction decoder's activation strobe and samples its control outputs.
- Evaluates the condition field against NZCV and gates the ALU/multiplier, register file, flag and PC write enables.
- Sits between the instruction memory port and the decoder/ALU/multiplier datapath.

---
 rtl/arm_pkg.sv | 35 +++
 rtl/arm_cond_check.sv | 39 +++
 rtl/arm_exec_sequencer.sv | 145 ++++++++++++++
 tb/tb_arm_exec_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM execution sequencer: FSM states,
// condition-code encodings and NZCV bit positions.
package arm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MULT,
    ST_WB
  } state_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition-field evaluator; the reserved code 4'hF
// is treated as always.
module arm_cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = nzcv[NZCV_N];
  assign w_z = nzcv[NZCV_Z];
  assign w_c = nzcv[NZCV_C];
  assign w_v = nzcv[NZCV_V];

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = ~w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = ~w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = ~w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = ~w_v;
      COND_HI: pass = w_c & ~w_z;
      COND_LS: pass = ~w_c | w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = ~w_z & (w_n == w_v);
      COND_LE: pass = w_z | (w_n != w_v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/arm_exec_sequencer.sv
// Fetch/decode/execute/writeback sequencer for one ARM instruction at a time.
// Define ARM_EXEC_COND_EN to enable condition-code evaluation and skipping.
module arm_exec_sequencer
  import arm_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             fetch_req,
  input  logic             fetch_ack,
  input  logic [31:0]      fetch_data,
  output logic [31:0]      ir,
  output logic             dec_active,
  input  logic             dec_reg_w,
  input  logic             dec_mult_hot,
  input  logic             dec_s_on,
  input  logic [3:0]       flags_nzcv,
  output logic             alu_en,
  output logic             mult_en,
  output logic             reg_we,
  output logic             flags_we,
  output logic             pc_inc,
  output logic             skipped,
  output logic             busy,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int MC_W = 4;

  state_t           r_state;
  state_t           w_next_state;
  logic [31:0]      r_ir;
  logic             r_wr, r_sf, r_skp;
  logic [MC_W-1:0]  r_mcnt;
  logic [CNT_W-1:0] r_retired;
  logic             r_fetch_req, r_dec_active, r_alu_en, r_mult_en;
  logic             r_reg_we, r_flags_we, r_pc_inc, r_skipped, r_busy;
  logic             w_pass;
  logic             w_wr_next, w_sf_next, w_skp_next;

`ifdef ARM_EXEC_COND_EN
  arm_cond_check u_cond (
    .cond (r_ir[31:28]),
    .nzcv (flags_nzcv),
    .pass (w_pass)
  );
`else
  logic w_unused_nzcv;
  assign w_unused_nzcv = ^flags_nzcv;
  assign w_pass        = 1'b1;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (run) w_next_state = ST_FETCH;
      ST_FETCH:  if (fetch_ack) w_next_state = ST_DECODE;
      ST_DECODE: begin
        if (!w_pass)           w_next_state = ST_WB;
        else if (dec_mult_hot) w_next_state = ST_MULT;
        else                   w_next_state = ST_EXEC;
      end
      ST_EXEC:   w_next_state = ST_WB;
      ST_MULT:   if (r_mcnt == '0) w_next_state = ST_WB;
      ST_WB:     w_next_state = run ? ST_FETCH : ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Latched decoder bits as they will be after this edge; the registered
  // outputs are decoded from these so they line up with the new state.
  always_comb begin
    w_wr_next  = (r_state == ST_DECODE) ? dec_reg_w : r_wr;
    w_sf_next  = (r_state == ST_DECODE) ? dec_s_on  : r_sf;
    w_skp_next = r_skp;
    if (r_state == ST_DECODE)  w_skp_next = ~w_pass;
    else if (r_state == ST_WB) w_skp_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ir         <= '0;
      r_wr         <= 1'b0;
      r_sf         <= 1'b0;
      r_skp        <= 1'b0;
      r_mcnt       <= '0;
      r_retired    <= '0;
      r_fetch_req  <= 1'b0;
      r_dec_active <= 1'b0;
      r_alu_en     <= 1'b0;
      r_mult_en    <= 1'b0;
      r_reg_we     <= 1'b0;
      r_flags_we   <= 1'b0;
      r_pc_inc     <= 1'b0;
      r_skipped    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_wr    <= w_wr_next;
      r_sf    <= w_sf_next;
      r_skp   <= w_skp_next;

      if (r_state == ST_FETCH && fetch_ack) r_ir <= fetch_data;

      // Loaded with MULT_LAT-1 so MULT is left on the cycle it reads zero.
      if (r_state == ST_DECODE)
        r_mcnt <= MC_W'(MULT_LAT - 1);
      else if (r_state == ST_MULT && r_mcnt != '0)
        r_mcnt <= r_mcnt - MC_W'(1);

      if (r_state == ST_WB) r_retired <= r_retired + CNT_W'(1);

      r_fetch_req  <= (w_next_state == ST_FETCH);
      r_dec_active <= (w_next_state == ST_DECODE);
      r_alu_en     <= (w_next_state == ST_EXEC);
      r_mult_en    <= (w_next_state == ST_MULT);
      r_pc_inc     <= (w_next_state == ST_WB);
      r_reg_we     <= (w_next_state == ST_WB) & w_wr_next & ~w_skp_next;
      r_flags_we   <= (w_next_state == ST_WB) & w_sf_next & ~w_skp_next;
`ifdef ARM_EXEC_COND_EN
      r_skipped    <= (w_next_state == ST_WB) & w_skp_next;
`else
      r_skipped    <= 1'b0;
`endif
      r_busy       <= (w_next_state != ST_IDLE);
    end
  end

  assign fetch_req   = r_fetch_req;
  assign ir          = r_ir;
  assign dec_active  = r_dec_active;
  assign alu_en      = r_alu_en;
  assign mult_en     = r_mult_en;
  assign reg_we      = r_reg_we;
  assign flags_we    = r_flags_we;
  assign pc_inc      = r_pc_inc;
  assign skipped     = r_skipped;
  assign busy        = r_busy;
  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_arm_exec_sequencer.sv
// Self-checking bench for arm_exec_sequencer: directed vector table, randomized
// instructions against a condition/latency model, and a reset during multiply.
module tb_arm_exec_sequencer;

  localparam int MULT_LAT = 4;
  localparam int CNT_W    = 32;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic             fetch_req;
  logic             fetch_ack;
  logic [31:0]      fetch_data;
  logic [31:0]      ir;
  logic             dec_active;
  logic             dec_reg_w;
  logic             dec_mult_hot;
  logic             dec_s_on;
  logic [3:0]       flags_nzcv;
  logic             alu_en;
  logic             mult_en;
  logic             reg_we;
  logic             flags_we;
  logic             pc_inc;
  logic             skipped;
  logic             busy;
  logic [CNT_W-1:0] retired_cnt;

  arm_exec_sequencer #(.MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .fetch_req    (fetch_req),
    .fetch_ack    (fetch_ack),
    .fetch_data   (fetch_data),
    .ir           (ir),
    .dec_active   (dec_active),
    .dec_reg_w    (dec_reg_w),
    .dec_mult_hot (dec_mult_hot),
    .dec_s_on     (dec_s_on),
    .flags_nzcv   (flags_nzcv),
    .alu_en       (alu_en),
    .mult_en      (mult_en),
    .reg_we       (reg_we),
    .flags_we     (flags_we),
    .pc_inc       (pc_inc),
    .skipped      (skipped),
    .busy         (busy),
    .retired_cnt  (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    bit          regW;
    bit          mult;
    bit          sOn;
    logic [3:0]  nzcv;
    int          waits;
    int          expAlu;
    int          expMult;
    bit          expRegWe;
    bit          expFlagsWe;
    bit          expSkipped;
    int          expCycles;
  } vec_t;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] prevIr;
  int          retiredModel;

  int obsCycles, obsFetch, obsDec, obsAlu, obsMult, obsMultSpan;
  int obsRegWeTot, obsFlagsWeTot, obsSkipTot, obsPcTot;
  bit wbRegWe, wbFlagsWe, wbSkipped, sawWb, irStableBad;
  logic [31:0] obsIrDec;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference condition test: odd codes negate the even code below them,
  // except that 14 and 15 both mean "always".
  function automatic bit condPass(input logic [3:0] c, input logic [3:0] f);
`ifdef ARM_EXEC_COND_EN
    bit n = f[3];
    bit z = f[2];
    bit cf = f[1];
    bit v = f[0];
    bit base;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[0] && c != 4'hF) ? !base : base;
`else
    return 1'b1;
`endif
  endfunction

  function automatic vec_t modelVec(input logic [31:0] instr, input bit regW, input bit mult,
                                    input bit sOn, input logic [3:0] nzcv, input int waits);
    vec_t v;
    bit pass;
    pass         = condPass(instr[31:28], nzcv);
    v.instr      = instr;
    v.regW       = regW;
    v.mult       = mult;
    v.sOn        = sOn;
    v.nzcv       = nzcv;
    v.waits      = waits;
    v.expAlu     = (pass && !mult) ? 1 : 0;
    v.expMult    = (pass && mult) ? MULT_LAT : 0;
    v.expRegWe   = pass && regW;
    v.expFlagsWe = pass && sOn;
    v.expSkipped = !pass;
    v.expCycles  = waits + (!pass ? 3 : (mult ? 3 + MULT_LAT : 4));
    return v;
  endfunction

  // Drives one instruction from IDLE to WB, acting as memory and decoder,
  // and records what the sequencer did on each cycle.
  task automatic applyStimulus(input vec_t v, input bit dropEarly, input bit scramble,
                               input int resetAtMult);
    int startCyc  = -1;
    int multFirst = -1;
    int multLast  = -1;
    obsCycles = 0; obsFetch = 0; obsDec = 0; obsAlu = 0; obsMult = 0; obsMultSpan = 0;
    obsRegWeTot = 0; obsFlagsWeTot = 0; obsSkipTot = 0; obsPcTot = 0;
    wbRegWe = 0; wbFlagsWe = 0; wbSkipped = 0; sawWb = 0; irStableBad = 0; obsIrDec = '0;
    fetch_data   = v.instr;
    dec_reg_w    = v.regW;
    dec_mult_hot = v.mult;
    dec_s_on     = v.sOn;
    flags_nzcv   = v.nzcv;
    fetch_ack    = 1'b0;
    run          = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (fetch_req) begin
        obsFetch++;
        if (startCyc < 0) startCyc = cyc;
        if (ir !== prevIr) irStableBad = 1;
        if (dropEarly) run = 1'b0;
        fetch_ack = (obsFetch > v.waits);
      end else begin
        fetch_ack = 1'b0;
      end
      if (dec_active) begin
        obsDec++;
        obsIrDec = ir;
      end
      if (alu_en) obsAlu++;
      if (mult_en) begin
        obsMult++;
        if (multFirst < 0) multFirst = cyc;
        multLast = cyc;
      end
      if (reg_we)   obsRegWeTot++;
      if (flags_we) obsFlagsWeTot++;
      if (skipped)  obsSkipTot++;
      if (alu_en || mult_en || pc_inc) begin
        run = 1'b0;
        if (scramble) begin
          flags_nzcv = 4'($urandom);
          dec_reg_w  = 1'($urandom);
          dec_s_on   = 1'($urandom);
        end
      end
      if (resetAtMult > 0 && obsMult == resetAtMult) begin
        rst_n = 1'b0;
        break;
      end
      if (pc_inc) begin
        obsPcTot++;
        wbRegWe   = reg_we;
        wbFlagsWe = flags_we;
        wbSkipped = skipped;
        obsCycles = cyc - startCyc + 1;
        sawWb     = 1;
        break;
      end
    end
    obsMultSpan = (multFirst < 0) ? 0 : multLast - multFirst + 1;
  endtask

  task automatic checkInstr(input string tag, input vec_t v);
    checkOutput({tag, "_wb_seen"},    sawWb, 1);
    checkOutput({tag, "_cycles"},     obsCycles, v.expCycles);
    checkOutput({tag, "_fetch_req"},  obsFetch, v.waits + 1);
    checkOutput({tag, "_ir_stable"},  irStableBad, 0);
    checkOutput({tag, "_dec_active"}, obsDec, 1);
    checkOutput({tag, "_ir"},         obsIrDec, v.instr);
    checkOutput({tag, "_alu_en"},     obsAlu, v.expAlu);
    checkOutput({tag, "_mult_en"},    obsMult, v.expMult);
    checkOutput({tag, "_mult_span"},  obsMultSpan, v.expMult);
    checkOutput({tag, "_reg_we"},     wbRegWe, v.expRegWe);
    checkOutput({tag, "_reg_we_tot"}, obsRegWeTot, v.expRegWe);
    checkOutput({tag, "_flags_we"},   wbFlagsWe, v.expFlagsWe);
    checkOutput({tag, "_flags_tot"},  obsFlagsWeTot, v.expFlagsWe);
    checkOutput({tag, "_skipped"},    wbSkipped, v.expSkipped);
    checkOutput({tag, "_skip_tot"},   obsSkipTot, v.expSkipped);
    checkOutput({tag, "_pc_inc"},     obsPcTot, 1);
    prevIr = v.instr;
    retiredModel++;
    @(negedge clk);
    checkOutput({tag, "_idle_busy"},  busy, 0);
    checkOutput({tag, "_idle_fetch"}, fetch_req, 0);
    checkOutput({tag, "_retired"},    retired_cnt, retiredModel);
  endtask

  vec_t table_v[9];
  vec_t rv;

  initial begin
    rst_n = 1'b0; run = 1'b0; fetch_ack = 1'b0; fetch_data = '0;
    dec_reg_w = 1'b0; dec_mult_hot = 1'b0; dec_s_on = 1'b0; flags_nzcv = '0;
    prevIr = '0; retiredModel = 0;

    table_v[0] = '{32'hE0811002, 1, 0, 0, 4'b0000, 0, 1, 0, 1, 0, 0, 4};
    table_v[1] = '{32'hE0000291, 1, 1, 0, 4'b0000, 0, 0, 4, 1, 0, 0, 7};
`ifdef ARM_EXEC_COND_EN
    table_v[2] = '{32'h00811002, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 3};
    table_v[6] = '{32'h10000291, 1, 1, 0, 4'b0100, 0, 0, 0, 0, 0, 1, 3};
    table_v[7] = '{32'hC0811002, 1, 0, 1, 4'b1000, 1, 0, 0, 0, 0, 1, 4};
`else
    table_v[2] = '{32'h00811002, 1, 0, 0, 4'b0000, 0, 1, 0, 1, 0, 0, 4};
    table_v[6] = '{32'h10000291, 1, 1, 0, 4'b0100, 0, 0, 4, 1, 0, 0, 7};
    table_v[7] = '{32'hC0811002, 1, 0, 1, 4'b1000, 1, 1, 0, 1, 1, 0, 5};
`endif
    table_v[3] = '{32'h00811002, 1, 0, 0, 4'b0100, 0, 1, 0, 1, 0, 0, 4};
    table_v[4] = '{32'hE1510002, 0, 0, 1, 4'b0000, 0, 1, 0, 0, 1, 0, 4};
    table_v[5] = '{32'hE0811002, 1, 0, 0, 4'b0000, 3, 1, 0, 1, 0, 0, 7};
    table_v[8] = '{32'hF0811002, 1, 0, 1, 4'b0000, 0, 1, 0, 1, 1, 0, 4};

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {fetch_req, dec_active, alu_en, mult_en, reg_we, flags_we, pc_inc, skipped, busy}, 0);
    checkOutput("reset_ir", ir, 0);
    checkOutput("reset_retired", retired_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_no_run", busy, 0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(table_v[i], 1'b0, 1'b0, 0);
      checkInstr($sformatf("vec%0d", i), table_v[i]);
    end

    $display("[TB] randomized instructions");
    for (int i = 0; i < 30; i++) begin
      rv = modelVec({4'($urandom), 28'($urandom)}, 1'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), int'($urandom_range(0, 3)));
      applyStimulus(rv, 1'($urandom), 1'b1, 0);
      checkInstr($sformatf("rnd%0d", i), rv);
    end

    $display("[TB] reset during multiply");
    applyStimulus(table_v[1], 1'b0, 1'b0, 2);
    @(negedge clk);
    checkOutput("rstmul_mult_seen", obsMult, 2);
    checkOutput("rstmul_busy", busy, 0);
    checkOutput("rstmul_mult_en", mult_en, 0);
    checkOutput("rstmul_reg_we", reg_we, 0);
    checkOutput("rstmul_pc_inc", pc_inc, 0);
    checkOutput("rstmul_ir", ir, 0);
    checkOutput("rstmul_retired", retired_cnt, 0);
    rst_n = 1'b1;
    prevIr = '0;
    retiredModel = 0;
    @(negedge clk);
    checkOutput("rstmul_stays_idle", busy, 0);
    checkOutput("rstmul_no_wb", sawWb, 0);

    applyStimulus(table_v[0], 1'b0, 1'b0, 0);
    checkInstr("after_reset", table_v[0]);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
